randomizer_scheduler: RTL



---
 rtl/randomizer_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 47 ++++
 rtl/randomizer_scheduler.sv | 123 ++++++++++++
 3 files changed

// File: rtl/randomizer_pkg.sv
// Shared definitions for the randomizer and its scheduler: width helpers and
// scheduler FSM encodings.
package randomizer_pkg;

  typedef enum logic {
    ST_AUTOSEED = 1'b0,
    ST_RUN      = 1'b1
  } sched_state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) result++;
    return result;
  endfunction

  // One extra code point so an out-of-range channel is always representable.
  function automatic int chan_width(input int n);
    return clog2(n + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching from last-granted+1,
// pointer held here and advanced only when the caller commits the grant.
module rr_arbiter
  import randomizer_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = idx_width(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] cand;
  logic          found;

  // NOTE: every variable driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(ptr_q) + k) % N);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples values from before the edge.
  always_ff @(posedge clk) begin
    if (!rst_n)
      ptr_q <= IW'(N - 1);
    else if (advance && found)
      ptr_q <= idx;
  end

endmodule

// File: rtl/randomizer_scheduler.sv
// Shares one multi-channel randomizer among NR_CHANNELS requesters and handles
// seed loads. Define RANDOMIZER_SCHEDULER_AUTOSEED_EN to seed all channels after reset.
module randomizer_scheduler
  import randomizer_pkg::*;
#(
  parameter int                      NR_CHANNELS  = 4,
  parameter int                      OUTPUT_WIDTH = 32,
  parameter logic [OUTPUT_WIDTH-1:0] SEED_INIT    = OUTPUT_WIDTH'(1),
  localparam int                     CHANNEL_WIDTH = chan_width(NR_CHANNELS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NR_CHANNELS-1:0]   req,
  output logic [NR_CHANNELS-1:0]   grant,
  input  logic                     seed_valid,
  input  logic [CHANNEL_WIDTH-1:0] seed_ch,
  input  logic [OUTPUT_WIDTH-1:0]  seed,
  output logic                     seed_ready,
  output logic [OUTPUT_WIDTH-1:0]  out_data,
  output logic [CHANNEL_WIDTH-1:0] out_ch,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     seed_err,
  output logic [CHANNEL_WIDTH-1:0] rndm_ch,
  output logic [OUTPUT_WIDTH-1:0]  rndm_seed,
  output logic                     rndm_init,
  output logic                     rndm_ready,
  input  logic [OUTPUT_WIDTH-1:0]  rndm_out
);

  localparam int IW = idx_width(NR_CHANNELS);

`ifdef RANDOMIZER_SCHEDULER_AUTOSEED_EN
  localparam sched_state_t RESET_STATE = ST_AUTOSEED;
`else
  localparam sched_state_t RESET_STATE = ST_RUN;
`endif

  sched_state_t             state_q, state_d;
  logic [CHANNEL_WIDTH-1:0] sweep;
  logic [NR_CHANNELS-1:0]   arb_gnt;
  logic [IW-1:0]            arb_idx;
  logic                     auto_init, run, seed_ok, seed_bad, advance;
  logic [OUTPUT_WIDTH-1:0]  raw_seed, auto_seed;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= RESET_STATE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_AUTOSEED && sweep == CHANNEL_WIDTH'(NR_CHANNELS - 1))
      state_d = ST_RUN;
  end

`ifdef RANDOMIZER_SCHEDULER_AUTOSEED_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                     sweep <= '0;
    else if (state_q == ST_AUTOSEED) sweep <= sweep + CHANNEL_WIDTH'(1);
  end
  assign busy = (state_q == ST_AUTOSEED);
`else
  assign sweep = '0;
  assign busy  = 1'b0;
`endif

  always_comb begin
    auto_init = (state_q == ST_AUTOSEED);
    run       = (state_q == ST_RUN);
    seed_ok   = seed_valid && seed_ready && (seed_ch <  CHANNEL_WIDTH'(NR_CHANNELS));
    seed_bad  = seed_valid && seed_ready && (seed_ch >= CHANNEL_WIDTH'(NR_CHANNELS));
    // A pending seed load takes the randomizer port; losers simply re-arbitrate.
    advance   = run && !seed_ok && (|req);
    raw_seed  = SEED_INIT + OUTPUT_WIDTH'(sweep);
    // All-ones is the LFSR lock-up state, so it is never loaded.
    auto_seed = (&raw_seed) ? '0 : raw_seed;
  end

  rr_arbiter #(.N(NR_CHANNELS)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .advance (advance),
    .gnt     (arb_gnt),
    .idx     (arb_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant      <= '0;
      seed_ready <= 1'b0;
      seed_err   <= 1'b0;
      rndm_init  <= 1'b0;
      rndm_ready <= 1'b0;
      rndm_ch    <= '0;
      rndm_seed  <= '0;
      out_valid  <= 1'b0;
      out_ch     <= '0;
    end else begin
      seed_ready <= (state_d == ST_RUN);
      seed_err   <= seed_bad;
      grant      <= advance ? arb_gnt : '0;
      rndm_ready <= advance;
      rndm_init  <= auto_init || seed_ok;
      if (auto_init) begin
        rndm_ch   <= sweep;
        rndm_seed <= auto_seed;
      end else if (seed_ok) begin
        rndm_ch   <= seed_ch;
        rndm_seed <= seed;
      end else if (advance) begin
        rndm_ch   <= CHANNEL_WIDTH'(arb_idx);
      end
      // Tag stage: the randomizer answers one cycle after rndm_ready.
      out_valid <= rndm_ready;
      if (rndm_ready) out_ch <= rndm_ch;
    end
  end

  assign out_data = rndm_out;

endmodule
